// File: rtl/masked_sbox_sched_pkg.sv
// ---------------------------------------------------------------------------
// masked_sbox_sched_pkg
//  Shared constants for the masked S-box scheduler: FSM state encodings,
//  batch-mode selectors and a constant clog2 helper used to size the
//  in-flight byte tags.
// ---------------------------------------------------------------------------
package masked_sbox_sched_pkg;

    // FSM state encodings (kept as plain 2-bit constants for legacy tools)
    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ISSUE = 2'd1;
    localparam logic [1:0] STATE_DRAIN = 2'd2;
    localparam logic [1:0] STATE_DONE  = 2'd3;

    // Batch modes
    localparam logic MODE_SUBBYTES = 1'b0;  // full 16-byte state
    localparam logic MODE_SUBWORD  = 1'b1;  // 4 key bytes, indices 0..3

    localparam int SUBWORD_BYTES = 4;

    // Ceiling log2, never below 1 so a tag index always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/masked_sbox_sched_tag_pipe.sv
// ---------------------------------------------------------------------------
// masked_sbox_sched_tag_pipe
//  LATENCY-deep shift register of {valid, idx} tags that travels alongside
//  the S-box pipeline. It advances every cycle because the S-box has no
//  enable; a bubble simply enters as an invalid tag.
// Ports
//  ClkxCI        clock, rising edge
//  RstxRI        asynchronous active-high reset, clears all tags
//  InValidxSI    tag valid entering stage 0
//  InIdxxDI      byte index entering stage 0
//  ValidxSO      valid bit of every stage (bit 0 = youngest)
//  LastValidxSO  valid bit of the oldest stage
//  LastIdxxDO    byte index of the oldest stage
// ---------------------------------------------------------------------------
module masked_sbox_sched_tag_pipe #(
    parameter int LATENCY = 4,
    parameter int IDXW    = 4
) (
    input  logic                ClkxCI,
    input  logic                RstxRI,
    input  logic                InValidxSI,
    input  logic [IDXW-1:0]     InIdxxDI,
    output logic [LATENCY-1:0]  ValidxSO,
    output logic                LastValidxSO,
    output logic [IDXW-1:0]     LastIdxxDO
);

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : gStage
            logic            validIn;
            logic [IDXW-1:0] idxIn;
            logic            validQ;
            logic [IDXW-1:0] idxQ;

            if (gi == 0) begin : gHead
                assign validIn = InValidxSI;
                assign idxIn   = InIdxxDI;
            end else begin : gBody
                assign validIn = gStage[gi-1].validQ;
                assign idxIn   = gStage[gi-1].idxQ;
            end

            always_ff @(posedge ClkxCI or posedge RstxRI) begin
                if (RstxRI) begin
                    validQ <= 1'b0;
                    idxQ   <= '0;
                end else begin
                    validQ <= validIn;
                    idxQ   <= idxIn;
                end
            end

            assign ValidxSO[gi] = validQ;
        end
    endgenerate

    assign LastValidxSO = gStage[LATENCY-1].validQ;
    assign LastIdxxDO   = gStage[LATENCY-1].idxQ;

endmodule

// File: rtl/masked_sbox_sched.sv
// ---------------------------------------------------------------------------
// masked_sbox_sched
//  Time-multiplexes one pipelined masked AES S-box across a batch of shared
//  bytes (16 state bytes or 4 key bytes). One shared byte is issued per cycle
//  when fresh randomness is available, each issued byte is tagged, and results
//  are written back into a shared output buffer when their tag leaves the
//  pipe. Shares are only moved, never combined.
// Ports
//  ClkxCI        clock, rising edge
//  RstxRI        asynchronous active-high reset (aborts a running batch)
//  StartxSI      start a batch; honoured only in IDLE or DONE
//  ModexSI       0: 16 bytes, 1: 4 bytes (indices 0..3)
//  DataInxDI     shared input bytes, byte k share s at [(k*SHARES+s)*8 +: 8]
//  RandValidxSI  PRNG offers fresh randomness this cycle
//  RandReadyxSO  randomness is consumed this cycle
//  SboxInxDO     shared byte to the S-box input register
//  SboxOutxDI    shared byte from the S-box output
//  DataOutxDO    shared result buffer, same layout as DataInxDI
//  BusyxSO       high while issuing or draining
//  DonexSO       one-cycle pulse after the last result is captured
//  ErrxSO        sticky: randomness was missing while bytes were in flight
// ---------------------------------------------------------------------------
module masked_sbox_sched
    import masked_sbox_sched_pkg::*;
#(
    parameter int SHARES  = 2,
    parameter int LATENCY = 4,
    parameter int NBYTES  = 16
) (
    input  logic                         ClkxCI,
    input  logic                         RstxRI,
    input  logic                         StartxSI,
    input  logic                         ModexSI,
    input  logic [8*SHARES*NBYTES-1:0]   DataInxDI,
    input  logic                         RandValidxSI,
    output logic                         RandReadyxSO,
    output logic [8*SHARES-1:0]          SboxInxDO,
    input  logic [8*SHARES-1:0]          SboxOutxDI,
    output logic [8*SHARES*NBYTES-1:0]   DataOutxDO,
    output logic                         BusyxSO,
    output logic                         DonexSO,
    output logic                         ErrxSO
);

    localparam int IDXW = clog2(NBYTES);
    localparam int SW   = 8 * SHARES;
    localparam int BUSW = SW * NBYTES;
    // Every pipe stage except the oldest one; those tags are still in flight
    // after the coming clock edge.
    localparam logic [LATENCY-1:0] EARLY_MASK = {LATENCY{1'b1}} >> 1;

    logic [1:0]       StatexDP, StatexDN;
    logic [IDXW-1:0]  IdxxDP, IdxxDN;
    logic [IDXW-1:0]  LastIdxxDP, LastIdxxDN;
    logic [BUSW-1:0]  DataLatchxDP, DataLatchxDN;
    logic [SW-1:0]    SboxInxDP, SboxInxDN;
    logic             InTagValidxDP, InTagValidxDN;
    logic [IDXW-1:0]  InTagIdxxDP, InTagIdxxDN;
    logic             ErrxDP, ErrxDN;

    logic [LATENCY-1:0] pipeValid;
    logic               lastValid;
    logic [IDXW-1:0]    lastIdx;
    logic               anyValid;
    logic               pending;
    logic               startAccept;
    logic [SW-1:0]      latchBytes [NBYTES];

    // The tag register next to SboxInxDP marks the byte sitting at the S-box
    // input; the pipe then covers the LATENCY internal S-box stages.
    masked_sbox_sched_tag_pipe #(
        .LATENCY (LATENCY),
        .IDXW    (IDXW)
    ) u_tag_pipe (
        .ClkxCI       (ClkxCI),
        .RstxRI       (RstxRI),
        .InValidxSI   (InTagValidxDP),
        .InIdxxDI     (InTagIdxxDP),
        .ValidxSO     (pipeValid),
        .LastValidxSO (lastValid),
        .LastIdxxDO   (lastIdx)
    );

    assign anyValid    = InTagValidxDP | (|pipeValid);
    assign pending     = InTagValidxDP | (|(pipeValid & EARLY_MASK));
    assign startAccept = StartxSI & ((StatexDP == STATE_IDLE) | (StatexDP == STATE_DONE));

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : gLatchByte
            assign latchBytes[gi] = DataLatchxDP[gi*SW +: SW];
        end
    endgenerate

    always_comb begin
        StatexDN      = StatexDP;
        IdxxDN        = IdxxDP;
        LastIdxxDN    = LastIdxxDP;
        DataLatchxDN  = DataLatchxDP;
        SboxInxDN     = '0;          // bubbles carry all-zero shares
        InTagValidxDN = 1'b0;
        InTagIdxxDN   = IdxxDP;
        ErrxDN        = ErrxDP;

        if (startAccept) begin
            DataLatchxDN = DataInxDI;
            LastIdxxDN   = (ModexSI == MODE_SUBWORD) ? IDXW'(SUBWORD_BYTES - 1)
                                                     : IDXW'(NBYTES - 1);
            IdxxDN       = '0;
            ErrxDN       = 1'b0;
        end else if (!RandValidxSI && anyValid) begin
            // The S-box keeps advancing without fresh masks: result is still
            // captured but its masking is no longer guaranteed.
            ErrxDN = 1'b1;
        end

        case (StatexDP)
            STATE_IDLE: begin
                if (StartxSI) begin
                    StatexDN = STATE_ISSUE;
                end
            end
            STATE_ISSUE: begin
                if (RandValidxSI) begin
                    SboxInxDN     = latchBytes[IdxxDP];
                    InTagValidxDN = 1'b1;
                    if (IdxxDP == LastIdxxDP) begin
                        StatexDN = STATE_DRAIN;   // counter saturates here
                    end else begin
                        IdxxDN = IdxxDP + 1'b1;
                    end
                end
            end
            STATE_DRAIN: begin
                if (!pending) begin
                    StatexDN = STATE_DONE;
                end
            end
            STATE_DONE: begin
                StatexDN = StartxSI ? STATE_ISSUE : STATE_IDLE;
            end
            default: begin
                StatexDN = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge ClkxCI or posedge RstxRI) begin
        if (RstxRI) begin
            StatexDP      <= STATE_IDLE;
            IdxxDP        <= '0;
            LastIdxxDP    <= '0;
            DataLatchxDP  <= '0;
            SboxInxDP     <= '0;
            InTagValidxDP <= 1'b0;
            InTagIdxxDP   <= '0;
            ErrxDP        <= 1'b0;
        end else begin
            StatexDP      <= StatexDN;
            IdxxDP        <= IdxxDN;
            LastIdxxDP    <= LastIdxxDN;
            DataLatchxDP  <= DataLatchxDN;
            SboxInxDP     <= SboxInxDN;
            InTagValidxDP <= InTagValidxDN;
            InTagIdxxDP   <= InTagIdxxDN;
            ErrxDP        <= ErrxDN;
        end
    end

    // Result buffer: one register per byte slot, written when the oldest tag
    // names that slot. Slots not named in a batch keep their value.
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : gOutByte
            logic [SW-1:0] byteQ;

            always_ff @(posedge ClkxCI or posedge RstxRI) begin
                if (RstxRI) begin
                    byteQ <= '0;
                end else if (lastValid && (lastIdx == IDXW'(gi))) begin
                    byteQ <= SboxOutxDI;
                end
            end

            assign DataOutxDO[gi*SW +: SW] = byteQ;
        end
    endgenerate

    assign SboxInxDO    = SboxInxDP;
    assign RandReadyxSO = (StatexDP == STATE_ISSUE) | anyValid;
    assign BusyxSO      = (StatexDP == STATE_ISSUE) | (StatexDP == STATE_DRAIN);
    assign DonexSO      = (StatexDP == STATE_DONE);
    assign ErrxSO       = ErrxDP;

endmodule

// File: tb/tb_masked_sbox_sched.sv
// ---------------------------------------------------------------------------
// tb_masked_sbox_sched
//  Drives batches through masked_sbox_sched with a reference 2-share S-box
//  (golden AES S-box on recombined shares, fresh output mask each cycle,
//  4 register stages). Expected bytes are queued at batch start and checked
//  when Done is seen.
// ---------------------------------------------------------------------------
module tb_masked_sbox_sched;

    localparam int SHARES  = 2;
    localparam int LATENCY = 4;
    localparam int NBYTES  = 16;
    localparam int SW      = 8 * SHARES;
    localparam int BUSW    = SW * NBYTES;

    logic             ClkxCI = 1'b0;
    logic             RstxRI;
    logic             StartxSI;
    logic             ModexSI;
    logic [BUSW-1:0]  DataInxDI;
    logic             RandValidxSI;
    logic             RandReadyxSO;
    logic [SW-1:0]    SboxInxDO;
    logic [SW-1:0]    SboxOutxDI;
    logic [BUSW-1:0]  DataOutxDO;
    logic             BusyxSO;
    logic             DonexSO;
    logic             ErrxSO;

    always #5 ClkxCI = ~ClkxCI;

    masked_sbox_sched #(
        .SHARES  (SHARES),
        .LATENCY (LATENCY),
        .NBYTES  (NBYTES)
    ) dut (
        .ClkxCI       (ClkxCI),
        .RstxRI       (RstxRI),
        .StartxSI     (StartxSI),
        .ModexSI      (ModexSI),
        .DataInxDI    (DataInxDI),
        .RandValidxSI (RandValidxSI),
        .RandReadyxSO (RandReadyxSO),
        .SboxInxDO    (SboxInxDO),
        .SboxOutxDI   (SboxOutxDI),
        .DataOutxDO   (DataOutxDO),
        .BusyxSO      (BusyxSO),
        .DonexSO      (DonexSO),
        .ErrxSO       (ErrxSO)
    );

    // ---------------- reference S-box --------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] aesSbox(input logic [7:0] v);
        logic [7:0] inv;
        logic [7:0] base;
        logic [7:0] e;
        inv  = 8'h01;
        base = v;
        e    = 8'hFE;   // v^254 is the field inverse (0 maps to 0)
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [15:0] maskedSbox(input logic [15:0] x, input logic [7:0] r);
        logic [7:0] s;
        s = aesSbox(x[7:0] ^ x[15:8]);
        return {s ^ r, r};
    endfunction

    logic [15:0] sbPipe [LATENCY];
    logic [7:0]  rndReg = 8'h5A;

    always @(posedge ClkxCI) begin
        rndReg    <= 8'($urandom);
        sbPipe[0] <= maskedSbox(SboxInxDO, rndReg);
        for (int i = 1; i < LATENCY; i++) begin
            sbPipe[i] <= sbPipe[i-1];
        end
    end
    assign SboxOutxDI = sbPipe[LATENCY-1];

    // ---------------- bookkeeping ------------------------------------------
    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] val;
    } exp_t;

    typedef struct {
        int mode;
        int rnd;
        int sf;
        int st;
        int p1;
        int p2;
        int expDone;
        int expErr;
        int chkIdx;
        int chkVal;
    } vec_t;

    exp_t       sbQ [$];
    vec_t       vecs [4];
    logic [7:0] curVals [NBYTES];
    logic [7:0] expBuf [NBYTES];
    int         cyc;
    int         sf;
    int         st;
    int         p1;
    int         p2;
    int         nTests;
    int         nFail;
    int         batchNo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nTests++;
        if (act !== expv) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] outByte(input int k);
        return DataOutxDO[k*SW +: 8] ^ DataOutxDO[k*SW + 8 +: 8];
    endfunction

    function automatic logic randOn(input int c);
        return !(c >= sf && c <= st);
    endfunction

    task automatic prepare(input int mode, input int rnd);
        logic [7:0] s0;
        int n;
        n = (mode != 0) ? 4 : NBYTES;
        for (int k = 0; k < NBYTES; k++) begin
            curVals[k] = (rnd != 0 || k >= n) ? 8'($urandom) : 8'(k);
            s0 = 8'($urandom);
            DataInxDI[k*SW +: 8]     = s0;
            DataInxDI[k*SW + 8 +: 8] = s0 ^ curVals[k];
            if (k < n) sbQ.push_back('{idx: 4'(k), val: aesSbox(curVals[k])});
        end
        ModexSI = (mode != 0);
    endtask

    task automatic step();
        @(posedge ClkxCI);
        #1;
        cyc++;
        if (cyc == p1 || cyc == p2) begin
            StartxSI  = 1'b1;
            DataInxDI = {8{$urandom}};
            ModexSI   = ~ModexSI;
        end else begin
            StartxSI = 1'b0;
        end
        RandValidxSI = randOn(cyc);
        #1;
    endtask

    task automatic launch(input int mode, input int rnd);
        prepare(mode, rnd);
        StartxSI = 1'b1;
        @(posedge ClkxCI);
        #1;
        cyc          = 0;
        StartxSI     = 1'b0;
        RandValidxSI = randOn(0);
        #1;
        check("start_busy", 32'(BusyxSO), 32'd1);
        check("start_err_clear", 32'(ErrxSO), 32'd0);
    endtask

    task automatic waitDone(output int dc);
        dc = -1;
        for (int i = 0; i < 120; i++) begin
            if (cyc == 1 && randOn(0))
                check("first_issue", 32'(SboxInxDO[7:0] ^ SboxInxDO[15:8]), 32'(curVals[0]));
            if (sf >= 0 && cyc == sf + 1)
                check("bubble_zero", 32'(SboxInxDO), 32'd0);
            if (DonexSO) begin
                dc = cyc;
                break;
            end
            step();
        end
        if (dc < 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL done_timeout: got no Done, expected Done within 120 cycles");
        end
    endtask

    task automatic checkResults();
        exp_t e;
        logic touched [NBYTES];
        for (int k = 0; k < NBYTES; k++) touched[k] = 1'b0;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            check($sformatf("result_byte%0d", e.idx), 32'(outByte(int'(e.idx))), 32'(e.val));
            expBuf[e.idx]  = e.val;
            touched[e.idx] = 1'b1;
        end
        for (int k = 0; k < NBYTES; k++) begin
            if (!touched[k]) check($sformatf("kept_byte%0d", k), 32'(outByte(k)), 32'(expBuf[k]));
        end
    endtask

    // ---------------- stimulus ---------------------------------------------
    initial begin
        int dc;
        logic seenDone;

        RstxRI       = 1'b1;
        StartxSI     = 1'b0;
        ModexSI      = 1'b0;
        RandValidxSI = 1'b0;
        DataInxDI    = '0;
        sf = -1; st = -2; p1 = -100; p2 = -100;
        nTests = 0; nFail = 0; cyc = 0; batchNo = 0;
        for (int k = 0; k < NBYTES; k++) expBuf[k] = 8'h00;
        for (int i = 0; i < LATENCY; i++) sbPipe[i] = 16'h0000;

        //          mode rnd  sf  st   p1    p2  done err chkIdx chkVal
        vecs[0] = '{0,   0,   -1, -2, -100, -100, 21, 0,  15, 'h76};
        vecs[1] = '{1,   0,   -1, -2, -100, -100,  9, 0,   3, 'h7B};
        vecs[2] = '{0,   1,    3,  5, -100, -100, 24, 1,  -1, 0};
        vecs[3] = '{0,   1,   -1, -2,    5,   15, 21, 0,  -1, 0};

        repeat (2) @(posedge ClkxCI);
        #1;
        check("rst_dataout", 32'(DataOutxDO == '0), 32'd1);
        check("rst_sboxin", 32'(SboxInxDO), 32'd0);
        check("rst_randready", 32'(RandReadyxSO), 32'd0);
        check("rst_busy", 32'(BusyxSO), 32'd0);
        check("rst_done", 32'(DonexSO), 32'd0);
        check("rst_err", 32'(ErrxSO), 32'd0);
        RstxRI = 1'b0;

        // Table-driven batches
        for (int v = 0; v < 4; v++) begin
            sf = vecs[v].sf; st = vecs[v].st; p1 = vecs[v].p1; p2 = vecs[v].p2;
            launch(vecs[v].mode, vecs[v].rnd);
            waitDone(dc);
            check("done_cycle", 32'(dc), 32'(vecs[v].expDone));
            check("err_at_done", 32'(ErrxSO), 32'(vecs[v].expErr));
            check("busy_at_done", 32'(BusyxSO), 32'd0);
            if (vecs[v].chkIdx >= 0)
                check("known_sbox", 32'(outByte(vecs[v].chkIdx)), 32'(vecs[v].chkVal));
            checkResults();
            $display("[TB] batch %0d mode %0d done cycle %0d err %0d", batchNo, vecs[v].mode, dc, ErrxSO);
            batchNo++;
            p1 = -100; p2 = -100;
            step();
            check("done_one_cycle", 32'(DonexSO), 32'd0);
            check("idle_not_busy", 32'(BusyxSO), 32'd0);
        end

        // Back-to-back: Start held during DONE launches the next batch directly
        sf = -1; st = -2;
        launch(1, 1);
        waitDone(dc);
        check("b2b_first_done", 32'(dc), 32'd9);
        checkResults();
        $display("[TB] batch %0d mode 1 done cycle %0d err %0d", batchNo, dc, ErrxSO);
        batchNo++;
        launch(1, 1);
        waitDone(dc);
        check("b2b_second_done", 32'(dc), 32'd9);
        checkResults();
        $display("[TB] batch %0d mode 1 done cycle %0d err %0d", batchNo, dc, ErrxSO);
        batchNo++;
        step();

        // Asynchronous reset in the middle of a batch
        launch(0, 1);
        while (cyc < 10) step();
        #2;
        RstxRI = 1'b1;
        #1;
        check("midrst_dataout", 32'(DataOutxDO == '0), 32'd1);
        check("midrst_sboxin", 32'(SboxInxDO), 32'd0);
        check("midrst_busy", 32'(BusyxSO), 32'd0);
        check("midrst_randready", 32'(RandReadyxSO), 32'd0);
        sbQ.delete();
        for (int k = 0; k < NBYTES; k++) expBuf[k] = 8'h00;
        @(posedge ClkxCI);
        #1;
        RstxRI = 1'b0;
        seenDone = 1'b0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (DonexSO) seenDone = 1'b1;
        end
        check("midrst_no_done", 32'(seenDone), 32'd0);
        $display("[TB] batch %0d mode 0 aborted by reset", batchNo);
        batchNo++;
        launch(0, 1);
        waitDone(dc);
        check("post_rst_done", 32'(dc), 32'd21);
        checkResults();
        $display("[TB] batch %0d mode 0 done cycle %0d err %0d", batchNo, dc, ErrxSO);
        batchNo++;
        step();

        // Randomness withheld from the start: nothing in flight, no error
        sf = 0; st = 100000;
        launch(1, 1);
        while (cyc < 8) step();
        check("starve_randready", 32'(RandReadyxSO), 32'd1);
        check("starve_busy", 32'(BusyxSO), 32'd1);
        check("starve_err", 32'(ErrxSO), 32'd0);
        check("starve_sboxin", 32'(SboxInxDO), 32'd0);
        st = 8;
        waitDone(dc);
        check("starve_done", 32'(dc), 32'd18);
        check("starve_err_end", 32'(ErrxSO), 32'd0);
        checkResults();
        $display("[TB] batch %0d mode 1 done cycle %0d err %0d", batchNo, dc, ErrxSO);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
